// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_pkg
//  Description : Shared state encodings and constants for the memory access
//                controller that sits in front of the data RAM/cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    MAC_IDLE     = 3'd0,
    MAC_RD_PROBE = 3'd1,
    MAC_RD_WAIT  = 3'd2,
    MAC_WR_WAIT  = 3'd3,
    MAC_DONE     = 3'd4
  } mac_state_t;

  // Miss/write penalty; must match the RAM's own wait threshold.
  localparam int MAC_WAIT_CYCLES = 200;

  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mac_wait_cnt
//  Description : Clear/increment wait counter with a saturating at_limit flag.
//                The count never passes LIMIT, so it can not wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_wait_cnt
  import mem_access_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LIMIT = MAC_WAIT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  assign at_limit = (count == LIMIT_VAL);

  // Counter register: clear wins over increment, increment holds at the limit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Sequences one load/store from the MEM stage into the data
//                RAM/cache, generating the wait count the RAM compares against
//                its penalty and stalling the pipeline for the whole access.
//                Optional macro MEM_ACC_STAT_EN adds hit/miss statistics ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = MAC_WAIT_CYCLES,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [3:0]       mem_sel_i,
  input  logic [31:0]      mem_data_i,
  output logic [31:0]      mem_data_o,
  output logic             stallreq_o,
  output logic             ram_ce_o,
  output logic             ram_we_o,
  output logic [31:0]      ram_addr_o,
  output logic [3:0]       ram_sel_o,
  output logic [31:0]      ram_data_o,
  output logic [CNT_W-1:0] ram_cnt_o,
  input  logic             ram_hit_i,
  input  logic [31:0]      ram_data_i
`ifdef MEM_ACC_STAT_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
`endif
);

  mac_state_t       state, state_next;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [3:0]       req_sel;
  logic [31:0]      req_data;
  logic             latch_req;
  logic             capture;
  logic             refill;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_at_limit;

  mac_wait_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .count    (cnt_q),
    .at_limit (cnt_at_limit)
  );

  // State register plus the latched request and returned load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MAC_IDLE;
      req_we     <= WRITE_DISABLE;
      req_addr   <= ZERO_WORD;
      req_sel    <= 4'h0;
      req_data   <= ZERO_WORD;
      mem_data_o <= ZERO_WORD;
    end else begin
      state <= state_next;
      if (latch_req) begin
        req_we   <= mem_we_i;
        req_addr <= mem_addr_i;
        req_sel  <= mem_sel_i;
        req_data <= mem_data_i;
      end
      if (capture) begin
        mem_data_o <= ram_data_i;
      end
    end
  end

  // Next-state and RAM control. A hit seen in RD_PROBE is deliberately
  // ignored: right after a refill it carries stale data.
  always_comb begin
    state_next = state;
    latch_req  = 1'b0;
    capture    = 1'b0;
    refill     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    ram_ce_o   = CHIP_DISABLE;
    ram_we_o   = WRITE_DISABLE;
    ram_cnt_o  = '0;
    case (state)
      MAC_IDLE: begin
        if (mem_req_i) begin
          latch_req  = 1'b1;
          cnt_clr    = 1'b1;
          state_next = mem_we_i ? MAC_WR_WAIT : MAC_RD_PROBE;
        end
      end
      MAC_RD_PROBE: begin
        ram_ce_o   = CHIP_ENABLE;
        cnt_inc    = 1'b1;          // count is zero here, so RD_WAIT starts at 1
        state_next = MAC_RD_WAIT;
      end
      MAC_RD_WAIT: begin
        ram_ce_o  = CHIP_ENABLE;
        ram_cnt_o = cnt_q;
        if (ram_hit_i) begin
          capture    = 1'b1;
          state_next = MAC_DONE;
        end else if (cnt_at_limit) begin
          refill     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = MAC_RD_PROBE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      MAC_WR_WAIT: begin
        ram_ce_o  = CHIP_ENABLE;
        ram_we_o  = WRITE_ENABLE;
        ram_cnt_o = cnt_q;
        if (cnt_at_limit) begin
          state_next = MAC_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      MAC_DONE: begin
        state_next = MAC_IDLE;
      end
      default: begin
        state_next = MAC_IDLE;
      end
    endcase
  end

  // Busy from the request cycle until DONE, even if the request is flushed.
  assign stallreq_o = (state != MAC_DONE) && (mem_req_i || (state != MAC_IDLE));
  assign ram_addr_o = req_addr;
  assign ram_sel_o  = req_sel;
  assign ram_data_o = req_data;

`ifdef MEM_ACC_STAT_EN
  logic refilled;

  // Hit/miss statistics; only a load that hits without any refill is a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= 32'h0;
      miss_cnt_o <= 32'h0;
      refilled   <= 1'b0;
    end else begin
      if (latch_req) begin
        refilled <= 1'b0;
      end
      if (refill) begin
        refilled   <= 1'b1;
        miss_cnt_o <= miss_cnt_o + 32'h1;
      end
      if (capture && !refilled) begin
        hit_cnt_o <= hit_cnt_o + 32'h1;
      end
    end
  end
`else
  // Write direction is carried to the RAM via state; the latched copy is
  // kept for visibility only.
  logic unused_req_we;
  assign unused_req_we = req_we;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Scoreboard bench for mem_access_ctrl with a small behavioural
//                RAM/cache model (256 words, one valid bit per word).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
  logic [3:0]  mem_sel_i;
  logic        stallreq_o, ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_cnt_o;
  logic [3:0]  ram_sel_o;
  logic        ram_hit;
  logic [31:0] ram_rdata;
`ifdef MEM_ACC_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  mem_access_ctrl dut (
`ifdef MEM_ACC_STAT_EN
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
`endif
    .clk        (clk),
    .rst        (rst),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .stallreq_o (stallreq_o),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o),
    .ram_cnt_o  (ram_cnt_o),
    .ram_hit_i  (ram_hit),
    .ram_data_i (ram_rdata)
  );

  // ---------------- RAM/cache model ----------------
  logic [31:0] wmem    [0:255];
  bit          written [0:255];
  bit          cached  [0:255];
  logic [7:0]  ram_idx;
  assign ram_idx = ram_addr_o[9:2];

  function automatic logic [31:0] init_word(input logic [7:0] i);
    if (i == 8'h01)      return 32'h1234_5678;
    else if (i == 8'h41) return 32'hA5A5_0104;
    else                 return {24'h0, i};
  endfunction

  function automatic logic [31:0] cur_word(input logic [7:0] i);
    return written[i] ? wmem[i] : init_word(i);
  endfunction

  function automatic bit is_cached(input logic [7:0] i);
    return cached[i] || (i == 8'h01);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Registered hit/data; a store commits and a read refills at cnt == 200,
  // and the hit registered at the refill edge carries stale data.
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      ram_hit <= 1'b0;
      if (ram_cnt_o == 32'd200) begin
        wmem[ram_idx]    <= merge(cur_word(ram_idx), ram_data_o, ram_sel_o);
        written[ram_idx] <= 1'b1;
        cached[ram_idx]  <= 1'b1;
      end
    end else if (ram_ce_o) begin
      if (ram_cnt_o == 32'd200 && !is_cached(ram_idx)) begin
        cached[ram_idx] <= 1'b1;
        ram_hit         <= 1'b1;
        ram_rdata       <= 32'hBAD0_BAD0;
      end else begin
        ram_hit   <= is_cached(ram_idx);
        ram_rdata <= cur_word(ram_idx);
      end
    end else begin
      ram_hit <= 1'b0;
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int          lat;
    int          we_cyc;
    int          max_cnt;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;
  bit   rst_seen = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  initial forever begin
    @(posedge clk);
    rst_seen = rst;
  end

  // Monitor: a falling stallreq_o marks DONE; compare against the queue head.
  initial begin
    int   stall_run, we_run, max_run;
    bit   prev_stall;
    exp_t e;
    stall_run = 0; we_run = 0; max_run = 0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        stall_run = 0; we_run = 0; max_run = 0; prev_stall = 1'b0;
      end else begin
        if (stallreq_o) begin
          stall_run++;
          if (ram_we_o) we_run++;
          if (int'(ram_cnt_o) > max_run) max_run = int'(ram_cnt_o);
        end else if (prev_stall) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_data",    mem_data_o,        e.data);
            chk("stall_cycles", 32'(stall_run),    32'(e.lat));
            chk("we_cycles",    32'(we_run),       32'(e.we_cyc));
            chk("max_cnt",      32'(max_run),      32'(e.max_cnt));
            chk("done_ce",      {31'h0, ram_ce_o}, 32'h0);
          end
          stall_run = 0; we_run = 0; max_run = 0;
        end
        prev_stall = stallreq_o;
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input bit pulse, input bit expect_done, input exp_t e);
    bit ok;
    @(posedge clk); #1;
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
    mem_data_i = data; mem_sel_i = 4'hF;
    if (expect_done) sb.push_back(e);
    @(posedge clk); #1;
    if (pulse) mem_req_i = 1'b0;
    if (expect_done) begin
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(posedge clk);
        if (sb.size() == 0) begin ok = 1'b1; break; end
      end
      #1 mem_req_i = 1'b0;
      if (!ok) begin
        total++;
        $display("FAIL done_timeout: no DONE within 1000 cycles for addr 0x%08h", addr);
        sb.delete();
      end
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input int lat, input int w, input int m);
    exp_t e;
    e.data = d; e.lat = lat; e.we_cyc = w; e.max_cnt = m;
    return e;
  endfunction

  initial begin
    bit found;
    rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = 32'h0; mem_data_i = 32'h0; mem_sel_i = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ce",    {31'h0, ram_ce_o},   32'h0);
    chk("rst_we",    {31'h0, ram_we_o},   32'h0);
    chk("rst_cnt",   ram_cnt_o,           32'h0);
    chk("rst_data",  mem_data_o,          32'h0);
    chk("rst_stall", {31'h0, stallreq_o}, 32'h0);

    // Load hit, load miss with refill.
    issue(1'b0, 32'h004, 32'h0, 1'b0, 1'b1, mk(32'h1234_5678, 3, 0, 1));
    issue(1'b0, 32'h104, 32'h0, 1'b0, 1'b1, mk(32'hA5A5_0104, 204, 0, 200));
`ifdef MEM_ACC_STAT_EN
    chk("stat_hit",  hit_cnt,  32'd1);
    chk("stat_miss", miss_cnt, 32'd1);
`endif

    // Store, then read it back; a store leaves mem_data_o unchanged.
    issue(1'b1, 32'h008, 32'hDEAD_BEEF, 1'b0, 1'b1, mk(32'hA5A5_0104, 202, 201, 200));
    issue(1'b0, 32'h008, 32'h0,         1'b0, 1'b1, mk(32'hDEAD_BEEF, 3, 0, 1));

    // Store aborted by reset at cnt == 50.
    issue(1'b1, 32'h004, 32'hCAFE_F00D, 1'b1, 1'b0, mk(32'h0, 0, 0, 0));
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ram_cnt_o == 32'd50) begin found = 1'b1; break; end
    end
    if (!found) begin
      total++;
      $display("FAIL abort_wait: ram_cnt_o never reached 50, got 0x%08h", ram_cnt_o);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ce",    {31'h0, ram_ce_o},   32'h0);
    chk("abort_cnt",   ram_cnt_o,           32'h0);
    chk("abort_stall", {31'h0, stallreq_o}, 32'h0);
    issue(1'b0, 32'h004, 32'h0, 1'b0, 1'b1, mk(32'h1234_5678, 3, 0, 1));

    // Request dropped after one cycle: access completes, now a cached hit.
    issue(1'b0, 32'h104, 32'h0, 1'b1, 1'b1, mk(32'hA5A5_0104, 3, 0, 1));

    repeat (3) @(posedge clk);
    if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
